// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write side:
// widths, writeback FSM states and the writeback request record.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write circular buffer. Every slot and its valid bit are visible
// so the owner can search for pending writes to a given register.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [ADDR_W-1:0]              i_push_addr,
  input  logic [DATA_W-1:0]              i_push_data,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_addr,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [PTR_W-1:0]               o_head_ptr,
  output logic [CNT_W-1:0]               o_count,
  output logic                           o_empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_ent_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   o_ent_data,
  output logic [DEPTH-1:0]               o_ent_valid
);

  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  logic                         w_full;
  logic                         w_do_push;
  logic                         w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  // Pushing into a full buffer is refused even if a pop happens this edge.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= {(DEPTH*ADDR_W){1'b0}};
      r_data  <= {(DEPTH*DATA_W){1'b0}};
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_addr[r_tail] <= i_push_addr;
        r_data[r_tail] <= i_push_data;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_do_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is valid when its age relative to the head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] age;
    o_ent_valid = {DEPTH{1'b0}};
    age         = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      age            = PTR_W'(i) - r_head;
      o_ent_valid[i] = (CNT_W'(age) < r_count);
    end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_head_ptr  = r_head;
  assign o_count     = r_count;
  assign o_ent_addr  = r_addr;
  assign o_ent_data  = r_data;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write initiator: buffers writeback requests, drains them as
// isolated single-cycle write pulses and offers bypass of pending writes.
module reg_writeback_ctrl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wbValid,
  output logic                       wbReady,
  input  logic [ADDR_W-1:0]          wbReg,
  input  logic [DATA_W-1:0]          wbData,
  output logic [ADDR_W-1:0]          writeReg,
  output logic [DATA_W-1:0]          writeData,
  output logic                       readWrite,
  input  logic [ADDR_W-1:0]          lookupRegA,
  input  logic [ADDR_W-1:0]          lookupRegB,
  output logic                       bypassHitA,
  output logic                       bypassHitB,
  output logic [DATA_W-1:0]          bypassDataA,
  output logic [DATA_W-1:0]          bypassDataB,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       idle
);

  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_state_e                    r_state;
  wb_state_e                    w_next_state;
  logic                         r_read_write;
  logic [ADDR_W-1:0]            r_write_reg;
  logic [DATA_W-1:0]            r_write_data;
  logic                         w_push;
  logic                         w_pop;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [PTR_W-1:0]             w_head_ptr;
  logic [CNT_W-1:0]             w_count;
  logic                         w_empty;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] w_ent_data;
  logic [DEPTH-1:0]             w_ent_valid;
  logic [DATA_W:0]              w_bypass_a;
  logic [DATA_W:0]              w_bypass_b;

  assign wbReady = (w_count < CNT_W'(DEPTH));
  // Register 0 is hard-wired, so its writes complete the handshake but are dropped.
  assign w_push  = wbValid && wbReady && (wbReg != {ADDR_W{1'b0}});

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_addr (wbReg),
    .i_push_data (wbData),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_ptr  (w_head_ptr),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_ent_addr  (w_ent_addr),
    .o_ent_data  (w_ent_data),
    .o_ent_valid (w_ent_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state; WRITE always returns to IDLE so back-to-back pulses stay separated.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next_state = WRITE;
          w_pop        = 1'b1;
        end else begin
          w_next_state = IDLE;
          w_pop        = 1'b0;
        end
      end
      WRITE: begin
        w_next_state = IDLE;
        w_pop        = 1'b0;
      end
      default: begin
        w_next_state = IDLE;
        w_pop        = 1'b0;
      end
    endcase
  end

  // Register-file write port; address/data hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_write <= 1'b0;
      r_write_reg  <= {ADDR_W{1'b0}};
      r_write_data <= {DATA_W{1'b0}};
    end else begin
      r_read_write <= (w_next_state == WRITE);
      if (w_pop) begin
        r_write_reg  <= w_head_addr;
        r_write_data <= w_head_data;
      end
    end
  end

  // Output stage is the oldest candidate; FIFO entries are scanned oldest to
  // newest so the newest matching write overrides everything before it.
  function automatic logic [DATA_W:0] bypass_lookup(input logic [ADDR_W-1:0] i_reg);
    logic             hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;
    hit  = 1'b0;
    data = {DATA_W{1'b0}};
    if ((r_state == WRITE) && (r_write_reg == i_reg)) begin
      hit  = 1'b1;
      data = r_write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_head_ptr + PTR_W'(k);
      if (w_ent_valid[idx] && (w_ent_addr[idx] == i_reg)) begin
        hit  = 1'b1;
        data = w_ent_data[idx];
      end
    end
    if (i_reg == {ADDR_W{1'b0}}) begin
      hit  = 1'b0;
      data = {DATA_W{1'b0}};
    end
    return {hit, data};
  endfunction

  assign w_bypass_a  = bypass_lookup(lookupRegA);
  assign w_bypass_b  = bypass_lookup(lookupRegB);

  assign bypassHitA  = w_bypass_a[DATA_W];
  assign bypassDataA = w_bypass_a[DATA_W-1:0];
  assign bypassHitB  = w_bypass_b[DATA_W];
  assign bypassDataB = w_bypass_b[DATA_W-1:0];

  assign readWrite   = r_read_write;
  assign writeReg    = r_write_reg;
  assign writeData   = r_write_data;
  assign pending     = w_count;
  assign idle        = w_empty && (r_state == IDLE);

endmodule
